// File: rtl/vdp18_vram_pkg.sv
// Shared types and sizes for the VDP VRAM arbiter.
package vdp18_vram_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 8;
    localparam int FAIR_CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        STROBE,
        DATA
    } vram_state_e;

    typedef enum logic {
        OWN_VID,
        OWN_CPU
    } vram_owner_e;

endpackage

// File: rtl/vdp18_vram_grant.sv
// Combinational grant decision between video fetch and the CPU port.
// A requester whose ack is high this cycle is ignored, so a held request never double-grants.
import vdp18_vram_pkg::*;

module vdp18_vram_grant #(
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic               vid_req,
    input  logic               cpu_req,
    input  logic               vid_ack,
    input  logic               cpu_ack,
    input  logic [FAIR_CW-1:0] fair_cnt,
    output logic               grant_vid,
    output logic               grant_cpu
);

    logic vid_ok;
    logic cpu_ok;
    logic cpu_forced;

    always_comb begin
        vid_ok     = vid_req & ~vid_ack;
        cpu_ok     = cpu_req & ~cpu_ack;
        // fair_cnt is tied to zero when fairness is not built, so this never fires then
        cpu_forced = (fair_cnt == FAIR_CW'(CPU_MAX_WAIT));
        grant_cpu  = cpu_ok & (~vid_ok | cpu_forced);
        grant_vid  = vid_ok & ~grant_cpu;
    end

endmodule

// File: rtl/vdp18_vram_arbiter.sv
// VRAM access sequencer shared by video fetch and the CPU data port; one access is four slot ticks.
// Define VDP18_VRAM_FAIRNESS_EN to force a CPU grant after CPU_MAX_WAIT video grants while it waits.
import vdp18_vram_pkg::*;

module vdp18_vram_arbiter #(
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clk_en_5m37_i,
    input  logic               vid_req_i,
    input  logic [VRAM_AW-1:0] vid_addr_i,
    output logic               vid_ack_o,
    output logic [VRAM_DW-1:0] vid_data_o,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [VRAM_AW-1:0] cpu_addr_i,
    input  logic [VRAM_DW-1:0] cpu_data_i,
    output logic               cpu_ack_o,
    output logic [VRAM_DW-1:0] cpu_data_o,
    output logic               ram_ce_o,
    output logic               ram_we_o,
    output logic [VRAM_AW-1:0] ram_addr_o,
    output logic [VRAM_DW-1:0] ram_d_o,
    input  logic [VRAM_DW-1:0] ram_d_i
);

    // state  | meaning
    // IDLE   | no access in flight; a tick may grant
    // ADDR   | latched address on the bus, chip enabled
    // STROBE | write strobe asserted for a CPU write
    // DATA   | read data sampled on the closing tick

    vram_state_e        state_q;
    vram_state_e        state_d;
    vram_owner_e        owner_q;
    logic               we_q;
    logic [VRAM_AW-1:0] addr_q;
    logic [VRAM_DW-1:0] wdata_q;
    logic [FAIR_CW-1:0] fair_cnt;
    logic               grant_vid;
    logic               grant_cpu;
    logic               take_grant;
    logic               done;

    vdp18_vram_grant #(
        .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) u_grant (
        .vid_req   (vid_req_i),
        .cpu_req   (cpu_req_i),
        .vid_ack   (vid_ack_o),
        .cpu_ack   (cpu_ack_o),
        .fair_cnt  (fair_cnt),
        .grant_vid (grant_vid),
        .grant_cpu (grant_cpu)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        done       = 1'b0;
        if (clk_en_5m37_i) begin
            case (state_q)
                IDLE: begin
                    take_grant = 1'b1;
                    if (grant_vid || grant_cpu) begin
                        state_d = ADDR;
                    end
                end
                ADDR:    state_d = STROBE;
                STROBE:  state_d = DATA;
                DATA: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ram_ce_o   = (state_q != IDLE);
    assign ram_we_o   = (state_q == STROBE) && (owner_q == OWN_CPU) && we_q;
    assign ram_addr_o = addr_q;
    assign ram_d_o    = wdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q    <= OWN_VID;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            vid_ack_o  <= 1'b0;
            cpu_ack_o  <= 1'b0;
            vid_data_o <= '0;
            cpu_data_o <= '0;
        end else begin
            vid_ack_o <= done && (owner_q == OWN_VID);
            cpu_ack_o <= done && (owner_q == OWN_CPU);
            if (take_grant && grant_vid) begin
                owner_q <= OWN_VID;
                addr_q  <= vid_addr_i;
                we_q    <= 1'b0;
            end else if (take_grant && grant_cpu) begin
                owner_q <= OWN_CPU;
                addr_q  <= cpu_addr_i;
                we_q    <= cpu_we_i;
                wdata_q <= cpu_data_i;
            end
            // writes leave the owner's read register untouched
            if (done && !we_q) begin
                if (owner_q == OWN_VID) begin
                    vid_data_o <= ram_d_i;
                end else begin
                    cpu_data_o <= ram_d_i;
                end
            end
        end
    end

`ifdef VDP18_VRAM_FAIRNESS_EN
    localparam logic [FAIR_CW-1:0] MAX_WAIT = FAIR_CW'(CPU_MAX_WAIT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fair_cnt <= '0;
        end else if (!cpu_req_i || (take_grant && grant_cpu)) begin
            fair_cnt <= '0;
        end else if (take_grant && grant_vid && (fair_cnt != MAX_WAIT)) begin
            fair_cnt <= fair_cnt + 1'b1;
        end
    end
`else
    assign fair_cnt = '0;
`endif

endmodule

// File: tb/tb_vdp18_vram_arbiter.sv
// Self-checking bench for vdp18_vram_arbiter: directed vector table, corner sequences, random vs. reference model.
`timescale 1ns/1ps

module tb_vdp18_vram_arbiter;

    localparam int MAXW = 4;
`ifdef VDP18_VRAM_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam logic [7:0] EXP_SEQ  = FAIR ? 8'(1 << MAXW) : 8'h00;
    localparam int         EXP_CACK = FAIR ? 1 : 0;

    logic        clk_i, reset_i, clk_en_5m37_i;
    logic        vid_req_i, vid_ack_o, cpu_req_i, cpu_we_i, cpu_ack_o;
    logic [13:0] vid_addr_i, cpu_addr_i, ram_addr_o;
    logic [7:0]  vid_data_o, cpu_data_i, cpu_data_o, ram_d_o, ram_d_i;
    logic        ram_ce_o, ram_we_o;

    vdp18_vram_arbiter #(.CPU_MAX_WAIT(MAXW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_5m37_i(clk_en_5m37_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_ack_o(vid_ack_o), .vid_data_o(vid_data_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_ack_o(cpu_ack_o), .cpu_data_o(cpu_data_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_d_o(ram_d_o), .ram_d_i(ram_d_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] pat(input logic [13:0] a);
        return (a == 14'h0800) ? 8'hC3 : (a[7:0] ^ {a[13:8], 2'b01});
    endfunction

    // bench-side VRAM
    logic [7:0] vram [0:16383];
    logic       mem_fill;
    assign ram_d_i = vram[ram_addr_o];
    always @(posedge clk_i) begin
        if (mem_fill) begin
            for (int a = 0; a < 16384; a++) vram[a] <= pat(14'(a));
        end else if (ram_we_o) begin
            vram[ram_addr_o] <= ram_d_o;
        end
    end

    int vectors, miscompares;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clk_step(input logic tk);
        clk_en_5m37_i = tk;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; vid_req_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        clk_step(1'b0);
        reset_i = 1'b0;
    endtask

    function automatic logic [41:0] dut_outs();
        return {ram_ce_o, ram_we_o, ram_addr_o, ram_d_o, vid_ack_o, cpu_ack_o, vid_data_o, cpu_data_o};
    endfunction

    typedef struct {
        logic rst, tk, vr; logic [13:0] va; logic cr, cw; logic [13:0] ca; logic [7:0] cd;
        logic ce, we; logic [13:0] ad; logic [7:0] dd; logic vk, ck; logic [7:0] vd, cdo;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic tk, logic vr, logic [13:0] va, logic cr, logic cw,
                                logic [13:0] ca, logic [7:0] cd, logic ce, logic we, logic [13:0] ad,
                                logic [7:0] dd, logic vk, logic ck, logic [7:0] vd, logic [7:0] cdo);
        vec_t v;
        v.rst = rst; v.tk = tk; v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ce = ce; v.we = we; v.ad = ad; v.dd = dd; v.vk = vk; v.ck = ck; v.vd = vd; v.cdo = cdo;
        return v;
    endfunction

    // reference model: access progress counted in ticks since the grant
    logic [7:0]  ref_mem [0:16383];
    int          m_tsg, m_cnt;
    logic        m_own, m_we, m_vack, m_cack;
    logic [13:0] m_addr;
    logic [7:0]  m_wd, m_vdata, m_cdata;

    task automatic model_step();
        logic vok, cok, gv, gc, fin;
        if (reset_i) begin
            m_tsg = 0; m_cnt = 0; m_own = 0; m_we = 0; m_vack = 0; m_cack = 0;
            m_addr = 0; m_wd = 0; m_vdata = 0; m_cdata = 0;
            return;
        end
        vok = vid_req_i && !m_vack;
        cok = cpu_req_i && !m_cack;
        gv = 0; gc = 0; fin = 0;
        if (clk_en_5m37_i && m_tsg == 0) begin
            gc = cok && (!vok || (FAIR && m_cnt == MAXW));
            gv = vok && !gc;
        end
        fin = clk_en_5m37_i && (m_tsg == 3);
        m_vack = fin && !m_own;
        m_cack = fin && m_own;
        if (fin && !m_we) begin
            if (m_own) m_cdata = ref_mem[m_addr];
            else       m_vdata = ref_mem[m_addr];
        end
        if (!cpu_req_i || gc) m_cnt = 0;
        else if (gv && m_cnt < MAXW) m_cnt++;
        if (gv) begin m_own = 0; m_addr = vid_addr_i; m_we = 0; end
        if (gc) begin m_own = 1; m_addr = cpu_addr_i; m_we = cpu_we_i; m_wd = cpu_data_i; end
        if (clk_en_5m37_i) begin
            if (m_tsg == 3) m_tsg = 0;
            else if (m_tsg != 0 || gv || gc) m_tsg++;
            if (m_tsg == 2 && m_own && m_we) ref_mem[m_addr] = m_wd;
        end
    endtask

    task automatic single_hold(input logic cpu, input logic we, input logic [13:0] a,
                               input logic [7:0] d, output int ngr, output int nack);
        logic hold, prev_ce;
        hold = 0; prev_ce = 0; ngr = 0; nack = 0;
        if (cpu) begin cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d; end
        else     begin vid_req_i = 1; vid_addr_i = a; end
        for (int c = 0; c < 20; c++) begin
            clk_step(1'b1);
            if (ram_ce_o && !prev_ce) ngr++;
            prev_ce = ram_ce_o;
            if (hold) begin vid_req_i = 0; cpu_req_i = 0; hold = 0; end
            if ((cpu ? cpu_ack_o : vid_ack_o) === 1'b1) begin nack++; hold = 1; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t, prev_ce, seen;
        logic [7:0]  gseq;
        int          ngr, nack, steps, v_st, c_st;

        vectors = 0; miscompares = 0;
        reset_i = 1; clk_en_5m37_i = 0; mem_fill = 0;
        vid_req_i = 0; vid_addr_i = 0; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
        @(negedge clk_i);
        mem_fill = 1;
        clk_step(1'b0);
        mem_fill = 0;

        // directed table: CPU write, video read, reset during a write strobe
        //                 rst tk vr va       cr cw ca       cd      ce we ad       dd     vk ck vd     cd
        tbl.push_back(mk(1, 0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 1, 0, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 1, 0, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 1, 1, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 1, 1, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 1, 0, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 1, 0, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 1, 1, 14'h1234, 8'h5A, 0, 0, 14'h1234, 8'h5A, 0, 1, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h1234, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 1, 0, 14'h0800, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 1, 0, 14'h0800, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 1, 0, 14'h0800, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 1, 0, 14'h0800, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 1, 0, 14'h0800, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 1, 0, 14'h0800, 8'h5A, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 1, 14'h0800, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0800, 8'h5A, 1, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0800, 8'h5A, 0, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0800, 8'h5A, 0, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 1, 1, 14'h0055, 8'hA7, 0, 0, 14'h0800, 8'h5A, 0, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 1, 1, 14'h0055, 8'hA7, 1, 0, 14'h0055, 8'hA7, 0, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 1, 1, 14'h0055, 8'hA7, 1, 0, 14'h0055, 8'hA7, 0, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 1, 1, 14'h0055, 8'hA7, 1, 1, 14'h0055, 8'hA7, 0, 0, 8'hC3, 8'h00));
        tbl.push_back(mk(1, 0, 0, 14'h0000, 1, 1, 14'h0055, 8'hA7, 0, 0, 14'h0000, 8'h00, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 0, 14'h0000, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 0, 8'h00, 8'h00));

        foreach (tbl[i]) begin
            reset_i = tbl[i].rst; vid_req_i = tbl[i].vr; vid_addr_i = tbl[i].va;
            cpu_req_i = tbl[i].cr; cpu_we_i = tbl[i].cw; cpu_addr_i = tbl[i].ca; cpu_data_i = tbl[i].cd;
            clk_step(tbl[i].tk);
            check($sformatf("table row %0d", i), dut_outs(),
                  {tbl[i].ce, tbl[i].we, tbl[i].ad, tbl[i].dd, tbl[i].vk, tbl[i].ck, tbl[i].vd, tbl[i].cdo});
        end

        // continuous video with a pending CPU read, ticks every other clock
        do_reset();
        vid_req_i = 1; vid_addr_i = 14'h0100; cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 14'h0200;
        ngr = 0; nack = 0; gseq = 0; prev_ce = 0; t = 1;
        for (int c = 0; c < 200 && ngr < 8; c++) begin
            clk_step(t); t = ~t;
            if (ram_ce_o && !prev_ce) begin
                if (ram_addr_o == 14'h0200) gseq[ngr] = 1'b1;
                ngr++;
            end
            prev_ce = ram_ce_o;
            if (cpu_ack_o) begin nack++; cpu_req_i = 0; end
        end
        check("starvation grant order", gseq, EXP_SEQ);
        check("starvation grant count", ngr, 8);
        check("starvation cpu acks", nack, EXP_CACK);

        // tick every clock, request held through its ack cycle
        do_reset();
        single_hold(0, 0, 14'h0300, 8'h00, ngr, nack);
        check("held vid req grants", ngr, 1);
        check("held vid req acks", nack, 1);
        check("held vid req data", vid_data_o, pat(14'h0300));
        single_hold(1, 1, 14'h0301, 8'h3C, ngr, nack);
        check("held cpu write grants", ngr, 1);
        check("held cpu write acks", nack, 1);
        check("cpu write keeps read data", cpu_data_o, 8'h00);
        single_hold(1, 0, 14'h0301, 8'h00, ngr, nack);
        check("held cpu read grants", ngr, 1);
        check("held cpu read acks", nack, 1);
        check("cpu read after write", cpu_data_o, 8'h3C);

        // both requests on the same IDLE tick
        do_reset();
        t = 1;
        vid_req_i = 1; vid_addr_i = 14'h0400; cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 14'h0401;
        clk_step(t); t = ~t;
        check("same tick video first", {ram_ce_o, ram_addr_o}, {1'b1, 14'h0400});
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            clk_step(t); t = ~t;
            if (vid_ack_o) seen = 1;
        end
        vid_req_i = 0;
        check("same tick vid ack seen", {seen, ram_ce_o}, 2'b10);
        steps = 0;
        for (int c = 0; c < 20 && !ram_ce_o; c++) begin
            clk_step(t); t = ~t; steps++;
        end
        check("cpu granted next tick", {steps, ram_ce_o, ram_addr_o}, {32'd2, 1'b1, 14'h0401});
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            clk_step(t); t = ~t;
            if (cpu_ack_o) seen = 1;
        end
        cpu_req_i = 0;
        check("same tick cpu read", {seen, cpu_data_o}, {1'b1, pat(14'h0401)});

        // random traffic against the reference model
        reset_i = 1; mem_fill = 1;
        for (int a = 0; a < 16384; a++) ref_mem[a] = pat(14'(a));
        clk_step(1'b0);
        mem_fill = 0;
        v_st = 0; c_st = 0; vid_req_i = 0; cpu_req_i = 0;
        for (int c = 0; c < 3000; c++) begin
            reset_i = (c == 0) || ($urandom_range(0, 299) == 0);
            clk_en_5m37_i = (c >= 1500) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (v_st == 1 && m_vack) begin
                if ($urandom_range(0, 1) == 0) begin v_st = 0; vid_req_i = 0; end
                else v_st = 2;
            end else if (v_st == 2) begin
                v_st = 0; vid_req_i = 0;
            end else if (v_st == 0 && $urandom_range(0, 2) == 0) begin
                v_st = 1; vid_req_i = 1; vid_addr_i = 14'($urandom_range(0, 63));
            end
            if (c_st == 1 && m_cack) begin
                if ($urandom_range(0, 1) == 0) begin c_st = 0; cpu_req_i = 0; end
                else c_st = 2;
            end else if (c_st == 2) begin
                c_st = 0; cpu_req_i = 0;
            end else if (c_st == 0 && $urandom_range(0, 2) == 0) begin
                c_st = 1; cpu_req_i = 1; cpu_we_i = 1'($urandom_range(0, 1));
                cpu_addr_i = 14'($urandom_range(0, 63)); cpu_data_i = 8'($urandom_range(0, 255));
            end
            model_step();
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("random cycle %0d", c), dut_outs(),
                  {(m_tsg != 0), (m_tsg == 2 && m_own && m_we), m_addr, m_wd,
                   m_vack, m_cack, m_vdata, m_cdata});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
